elevador: RTL and testbench

- Four-floor elevator controller, implemented as a Moore FSM.
- Two request inputs (A = go up, B = go down) move the car one floor per clock edge.
- The current floor is presented as a 2-bit code on Y1 (MSB) and Y2 (LSB).
- C is the door-open indicator.
- Standalone block, driven directly by board switches/buttons and feeding floor LEDs/7-seg logic.

---
 rtl/elevador.sv | 48 ++++
 tb/tb_elevador.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/elevador.sv
// rtl/elevador.sv - four-floor elevator controller, Moore FSM with registered floor code and door flag
module elevador (
  input  logic clk,
  input  logic reset,
  input  logic A,
  input  logic B,
  output logic Y1,
  output logic Y2,
  output logic C
);

  localparam logic [1:0] FLOOR_PB  = 2'b00;
  localparam logic [1:0] FLOOR_TOP = 2'b11;

  logic [1:0] floor_q, floor_d;
  logic       door_q, door_d;

  // State register; reset wins over any pending request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      floor_q <= FLOOR_PB;
      door_q  <= 1'b1;
    end else begin
      floor_q <= floor_d;
      door_q  <= door_d;
    end
  end

  // Conflicting requests or a request against a limit leave the car parked with the door open.
  always_comb begin
    floor_d = floor_q;
    door_d  = 1'b1;
    if (A && !B && floor_q != FLOOR_TOP) begin
      floor_d = floor_q + 2'd1;
      door_d  = 1'b0;
    end else if (!A && B && floor_q != FLOOR_PB) begin
      floor_d = floor_q - 2'd1;
      door_d  = 1'b0;
    end
  end

  always_comb begin
    Y1 = floor_q[1];
    Y2 = floor_q[0];
    C  = door_q;
  end

endmodule

// File: tb/tb_elevador.sv
// tb/tb_elevador.sv - self-checking bench for elevador against a floor-number reference model
module tb_elevador;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic A = 1'b0;
  logic B = 1'b0;
  logic Y1, Y2, C;

  int errors = 0;
  int checks = 0;

  // Reference model: floor as a plain integer 0..3, door as a flag.
  int model_floor = 0;
  int model_door  = 1;

  elevador dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .Y1    (Y1),
    .Y2    (Y2),
    .C     (C)
  );

  always #5 clk = ~clk;

  task automatic apply(input logic r, input logic a, input logic b);
    @(negedge clk);
    reset = r;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    if (!r) begin
      model_floor = 0;
      model_door  = 1;
    end else if (a && !b && model_floor < 3) begin
      model_floor = model_floor + 1;
      model_door  = 0;
    end else if (!a && b && model_floor > 0) begin
      model_floor = model_floor - 1;
      model_door  = 0;
    end else begin
      model_door = 1;
    end
  endtask

  task automatic test_reset();
    apply(1'b0, 1'b0, 1'b0);
    checks++;
    if ({Y1, Y2, C} !== 3'b001) begin
      errors++;
      $display("FAIL reset_edge: got {Y1,Y2,C}=%b expected 001", {Y1, Y2, C});
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 1'b0);
      checks++;
      if ({Y1, Y2, C} !== 3'b001) begin
        errors++;
        $display("FAIL idle_%0d: got {Y1,Y2,C}=%b expected 001", i, {Y1, Y2, C});
      end
    end
  endtask

  task automatic test_up_sweep();
    logic [1:0] exp_f [4] = '{2'b01, 2'b10, 2'b11, 2'b11};
    logic       exp_c [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b1, 1'b0);
      checks++;
      if ({Y1, Y2} !== exp_f[i] || C !== exp_c[i]) begin
        errors++;
        $display("FAIL up_sweep_%0d: got floor=%b C=%b expected floor=%b C=%b",
                 i, {Y1, Y2}, C, exp_f[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_down_sweep();
    logic [1:0] exp_f [4] = '{2'b10, 2'b01, 2'b00, 2'b00};
    logic       exp_c [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, 1'b1);
      checks++;
      if ({Y1, Y2} !== exp_f[i] || C !== exp_c[i]) begin
        errors++;
        $display("FAIL down_sweep_%0d: got floor=%b C=%b expected floor=%b C=%b",
                 i, {Y1, Y2}, C, exp_f[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_conflict();
    apply(1'b1, 1'b1, 1'b0);
    checks++;
    if ({Y1, Y2, C} !== 3'b010) begin
      errors++;
      $display("FAIL conflict_setup: got {Y1,Y2,C}=%b expected 010", {Y1, Y2, C});
    end
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b1, 1'b1);
      checks++;
      if ({Y1, Y2, C} !== 3'b011) begin
        errors++;
        $display("FAIL conflict_%0d: got {Y1,Y2,C}=%b expected 011", i, {Y1, Y2, C});
      end
    end
  endtask

  task automatic test_reset_mid_travel();
    apply(1'b1, 1'b1, 1'b0);
    checks++;
    if ({Y1, Y2, C} !== 3'b100) begin
      errors++;
      $display("FAIL mid_setup: got {Y1,Y2,C}=%b expected 100", {Y1, Y2, C});
    end
    apply(1'b0, 1'b1, 1'b0);
    checks++;
    if ({Y1, Y2, C} !== 3'b001) begin
      errors++;
      $display("FAIL mid_reset: got {Y1,Y2,C}=%b expected 001", {Y1, Y2, C});
    end
    apply(1'b1, 1'b1, 1'b0);
    checks++;
    if ({Y1, Y2, C} !== 3'b010) begin
      errors++;
      $display("FAIL mid_resume: got {Y1,Y2,C}=%b expected 010", {Y1, Y2, C});
    end
  endtask

  task automatic test_pulse();
    apply(1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0);
    checks++;
    if ({Y1, Y2, C} !== 3'b010) begin
      errors++;
      $display("FAIL pulse_move: got {Y1,Y2,C}=%b expected 010", {Y1, Y2, C});
    end
    apply(1'b1, 1'b0, 1'b0);
    checks++;
    if ({Y1, Y2, C} !== 3'b011) begin
      errors++;
      $display("FAIL pulse_hold: got {Y1,Y2,C}=%b expected 011", {Y1, Y2, C});
    end
  endtask

  task automatic test_random();
    logic r, a, b;
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 15) != 0);
      a = $urandom_range(0, 1);
      b = $urandom_range(0, 1);
      apply(r, a, b);
      checks++;
      if ({Y1, Y2} !== model_floor[1:0] || C !== model_door[0]) begin
        errors++;
        $display("FAIL random_%0d: got floor=%b C=%b expected floor=%b C=%b (reset=%b A=%b B=%b)",
                 i, {Y1, Y2}, C, model_floor[1:0], model_door[0], r, a, b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_sweep();
    test_down_sweep();
    test_conflict();
    test_reset_mid_travel();
    test_pulse();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
